div_tick_sched: RTL and testbench

DIV_TICK_SCHED -- requirements
Module: div_tick_sched

---
 rtl/div_tick_sched.sv | 97 +++++++++
 tb/tb_div_tick_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_tick_sched.sv
// Two-channel programmable tick/clock divider with glitch-free shadow-register
// reconfiguration and a shared phase-alignment (sync) request.
module div_tick_sched #(
  parameter int CW       = 8,
  parameter int DIV0_RST = 17,
  parameter int DIV1_RST = 8
) (
  input  logic          clk16M_in,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic          cfg_ch,
  input  logic [CW-1:0] cfg_div,
  input  logic          cfg_en,
  input  logic          sync_req,
  output logic [1:0]    ch_tick,
  output logic [1:0]    ch_clk,
  output logic [1:0]    upd_pend
);

  logic [1:0] pend;

  // A channel with an update in flight refuses further writes until it applies.
  assign cfg_ready = ~pend[cfg_ch];
  assign upd_pend  = pend;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam logic [CW-1:0] RST_DIV = (g == 0) ? CW'(DIV0_RST) : CW'(DIV1_RST);

    logic [CW-1:0] div_act;
    logic [CW-1:0] div_sh;
    logic [CW-1:0] cnt;
    logic          en_act;
    logic          en_sh;
    logic          tick_q;
    logic          clk_q;
    logic          pend_q;
    logic          load;
    logic          wrap;
    logic          apply;

    assign load  = cfg_valid && cfg_ready && (cfg_ch == 1'(g));
    assign wrap  = en_act && !sync_req && (cnt == div_act);
    // Shadow moves to active only at a period boundary (or at once when idle/syncing).
    assign apply = pend_q && (sync_req || !en_act || wrap);

    // NOTE: every register in this block uses <= so that all channel state
    // updates from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk16M_in or posedge rst) begin
      if (rst) begin
        div_act <= RST_DIV;
        en_act  <= 1'b1;
        div_sh  <= '0;
        en_sh   <= 1'b0;
        cnt     <= '0;
        tick_q  <= 1'b0;
        clk_q   <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (sync_req) begin
          cnt   <= '0;
          clk_q <= 1'b0;
        end else if (en_act) begin
          if (wrap) begin
            cnt    <= '0;
            tick_q <= 1'b1;
            clk_q  <= ~clk_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        if (apply) begin
          div_act <= div_sh;
          en_act  <= en_sh;
          pend_q  <= 1'b0;
          if (!en_sh) begin
            cnt   <= '0;
            clk_q <= 1'b0;
          end
        end

        if (load) begin
          div_sh <= cfg_div;
          en_sh  <= cfg_en;
          pend_q <= 1'b1;
        end
      end
    end

    assign pend[g]    = pend_q;
    assign ch_tick[g] = tick_q;
    assign ch_clk[g]  = clk_q;
  end

endmodule

// File: tb/tb_div_tick_sched.sv
// Self-checking bench for div_tick_sched: directed vector table, hand-written
// corner sequences and randomized traffic against an absolute-time reference model.
module tb_div_tick_sched;
  localparam int CW   = 8;
  localparam int DIV0 = 17;
  localparam int DIV1 = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          cfg_ch = 1'b0;
  logic [CW-1:0] cfg_div = '0;
  logic          cfg_en = 1'b0;
  logic          sync_req = 1'b0;
  logic [1:0]    ch_tick;
  logic [1:0]    ch_clk;
  logic [1:0]    upd_pend;

  always #5 clk = ~clk;

  div_tick_sched #(.CW(CW), .DIV0_RST(DIV0), .DIV1_RST(DIV1)) dut (
    .clk16M_in (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
    .sync_req  (sync_req),
    .ch_tick   (ch_tick),
    .ch_clk    (ch_clk),
    .upd_pend  (upd_pend)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is described by the absolute edge number of
  // its next tick and the parity of ticks since the last clear.
  int   m_n;
  int   m_div[2];
  bit   m_en[2];
  int   m_next[2];
  bit   m_par[2];
  int   m_sh_div[2];
  bit   m_sh_en[2];
  bit   m_pend[2];
  bit   m_tick[2];
  int   m_loads;
  int   dut_acc;
  logic rdy_seen;

  task automatic model_reset();
    m_n      = 0;
    m_div[0] = DIV0;
    m_div[1] = DIV1;
    for (int c = 0; c < 2; c++) begin
      m_en[c]     = 1'b1;
      m_next[c]   = m_div[c] + 1;
      m_par[c]    = 1'b0;
      m_sh_div[c] = 0;
      m_sh_en[c]  = 1'b0;
      m_pend[c]   = 1'b0;
      m_tick[c]   = 1'b0;
    end
  endtask

  task automatic model_edge(input bit v, input bit ch, input int d, input bit en, input bit s);
    m_n++;
    if (v && !m_pend[ch]) m_loads++;
    for (int c = 0; c < 2; c++) begin
      bit ld, wr, ap, was_en;
      ld     = v && (int'(ch) == c) && !m_pend[c];
      wr     = m_en[c] && !s && (m_n == m_next[c]);
      ap     = m_pend[c] && (s || !m_en[c] || wr);
      was_en = m_en[c];
      m_tick[c] = wr;
      if (ap) begin
        m_div[c]  = m_sh_div[c];
        m_en[c]   = m_sh_en[c];
        m_pend[c] = 1'b0;
      end
      if (s || wr || (ap && m_en[c] && !was_en)) m_next[c] = m_n + m_div[c] + 1;
      if (s) m_par[c] = 1'b0;
      else if (wr) m_par[c] = ~m_par[c];
      if (!m_en[c]) m_par[c] = 1'b0;
      if (ld) begin
        m_sh_div[c] = d;
        m_sh_en[c]  = en;
        m_pend[c]   = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check cfg_ready, clock, check registered outputs.
  task automatic cycle(input bit v, input bit ch, input int d, input bit en, input bit s);
    @(negedge clk);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_div   = CW'(d);
    cfg_en    = en;
    sync_req  = s;
    #1;
    rdy_seen = cfg_ready;
    check("model_ready", cfg_ready, !m_pend[ch]);
    if (v && cfg_ready) dut_acc++;
    model_edge(v, ch, d, en, s);
    @(posedge clk);
    #1;
    check("model_tick", ch_tick,  {m_tick[1], m_tick[0]});
    check("model_clk",  ch_clk,   {m_par[1], m_par[0]});
    check("model_pend", upd_pend, {m_pend[1], m_pend[0]});
  endtask

  typedef struct {
    int         cyc;
    logic       valid;
    logic       ch;
    int         div;
    logic       en;
    logic       sync;
    logic       ready;
    logic [1:0] tick;
    logic [1:0] clk;
    logic [1:0] pend;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int k, w, bad, first0, first1;

    // Defaults from reset, then a ch1 rewrite to div=3 in the middle of a period.
    tbl = '{
      '{ 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00},
      '{ 8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00},
      '{ 9, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00},
      '{10, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00},
      '{17, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00},
      '{18, 0, 0, 0, 0, 0, 1, 2'b11, 2'b01, 2'b00},
      '{19, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b00},
      '{27, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 2'b00},
      '{35, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 2'b00},
      '{36, 0, 0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00},
      '{41, 1, 1, 3, 1, 0, 1, 2'b00, 2'b00, 2'b10},
      '{42, 1, 1, 5, 1, 0, 0, 2'b00, 2'b00, 2'b10},
      '{43, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10},
      '{44, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10},
      '{45, 0, 1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00},
      '{46, 0, 1, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00},
      '{47, 0, 1, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00},
      '{48, 0, 1, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00},
      '{49, 0, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00},
      '{50, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00}
    };

    m_loads = 0;
    dut_acc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_tick",  ch_tick,   2'b00);
    check("rst_clk",   ch_clk,    2'b00);
    check("rst_pend",  upd_pend,  2'b00);
    check("rst_ready", cfg_ready, 1'b1);
    rst = 1'b0;
    model_reset();

    k = 0;
    for (int e = 1; e <= 50; e++) begin
      if (k < 20 && tbl[k].cyc == e) begin
        cycle(tbl[k].valid, tbl[k].ch, tbl[k].div, tbl[k].en, tbl[k].sync);
        check("tbl_ready", rdy_seen, tbl[k].ready);
        check("tbl_tick",  ch_tick,  tbl[k].tick);
        check("tbl_clk",   ch_clk,   tbl[k].clk);
        check("tbl_pend",  upd_pend, tbl[k].pend);
        k++;
      end else begin
        cycle(0, 0, 0, 0, 0);
      end
    end

    // Asynchronous reset while a ch1 update is pending.
    cycle(1, 1, 6, 1, 0);
    check("pend_before_rst", upd_pend, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tick",  ch_tick,   2'b00);
    check("async_rst_clk",   ch_clk,    2'b00);
    check("async_rst_pend",  upd_pend,  2'b00);
    check("async_rst_ready", cfg_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_pend", upd_pend, 2'b00);
    rst = 1'b0;
    model_reset();
    first0 = 0;
    first1 = 0;
    for (int e = 1; e <= 40; e++) begin
      cycle(0, 0, 0, 0, 0);
      if (ch_tick[0] && first0 == 0) first0 = e;
      if (ch_tick[1] && first1 == 0) first1 = e;
    end
    check("post_rst_first_tick1", first1, DIV1 + 1);
    check("post_rst_first_tick0", first0, DIV0 + 1);

    // Sync at arbitrary phases, then ticks line up on a common time base.
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 30)) cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      check("sync_clk",  ch_clk,  2'b00);
      check("sync_tick", ch_tick, 2'b00);
      bad = 0;
      for (int t = 1; t <= 36; t++) begin
        cycle(0, 0, 0, 0, 0);
        if (ch_tick !== {t % (DIV1 + 1) == 0, t % (DIV0 + 1) == 0}) bad++;
      end
      check("sync_align", bad, 0);
    end

    // Disable ch0, then re-enable it with div=0.
    cycle(1, 0, 17, 0, 0);
    w = 0;
    while (upd_pend[0] && w < 40) begin
      cycle(0, 0, 0, 0, 0);
      w++;
    end
    check("ch0_disable_applied", upd_pend[0], 1'b0);
    bad = 0;
    repeat (30) begin
      cycle(0, 0, 0, 0, 0);
      if (ch_clk[0] !== 1'b0 || ch_tick[0] !== 1'b0) bad++;
    end
    check("ch0_held_off", bad, 0);
    cycle(1, 0, 0, 1, 0);
    check("ch0_en_pend", upd_pend[0], 1'b1);
    cycle(0, 0, 0, 0, 0);
    check("ch0_en_applied", upd_pend[0], 1'b0);
    check("ch0_en_clk0",    ch_clk[0],   1'b0);
    check("ch0_en_tick0",   ch_tick[0],  1'b0);
    cycle(0, 0, 0, 0, 0);
    check("ch0_div0_clk_a",  ch_clk[0],  1'b1);
    check("ch0_div0_tick_a", ch_tick[0], 1'b1);
    cycle(0, 0, 0, 0, 0);
    check("ch0_div0_clk_b",  ch_clk[0],  1'b0);
    check("ch0_div0_tick_b", ch_tick[0], 1'b1);
    cycle(0, 0, 0, 0, 0);
    check("ch0_div0_clk_c",  ch_clk[0],  1'b1);

    // cfg_valid held high towards ch1.
    m_loads = 0;
    dut_acc = 0;
    repeat (200) cycle(1, 1, $urandom_range(0, 5), 1, 0);
    check("cont_valid_accepts", dut_acc, m_loads);

    // Randomized traffic.
    repeat (2500) begin
      cycle($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)), $urandom_range(0, 12),
            $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
